instr_aligner: RTL
==================

INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 SHALL have parameter DEPTH, default 8: buffer capacity in 16-bit halfwords; legal values are even and >= 4.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC of the first instruction after reset; bits [1:0] are zero.
REQ-003 SHALL have parameter ENABLE_C, default 1: 1 enables RVC 16-bit instructions; 0 makes every instruction 32-bit.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port fetch_valid, input, 1: fetch_data holds the next sequential aligned 32-bit fetch word.
REQ-007 SHALL have port fetch_ready, output, 1: the block accepts a fetch word this cycle.
REQ-008 SHALL have port fetch_data, input, 32: fetch word; [15:0] is the lower-address halfword.
REQ-009 SHALL have port redirect, input, 1: flush and restart at redirect_pc.
REQ-010 SHALL have port redirect_pc, input, 32: new PC; bit 0 is ignored.
REQ-011 SHALL have port out_valid, output, 1: a complete instruction is presented.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the instruction.
REQ-013 SHALL have port out_instr, output, 32: the instruction; a 16-bit instruction is zero-extended in [15:0].
REQ-014 SHALL have port out_pc, output, 32: PC of out_instr.
REQ-015 SHALL have port out_compressed, output, 1: out_instr is 16-bit (head[1:0] != 2'b11 and ENABLE_C=1).
REQ-016 SHALL have port out_illegal, output, 1: ENABLE_C=0 and head[1:0] != 2'b11.
REQ-017 SHALL have port level, output, $clog2(DEPTH+1): current halfword occupancy.

Function
REQ-018 SHALL hold the halfwords in a FIFO of DEPTH entries, with head PC register pc_q and drop_low flag.
REQ-019 SHALL assert fetch_ready = !redirect && (level <= DEPTH-2), from current level only; a same-cycle pop grants no credit.
REQ-020 SHALL, on a fetch handshake with drop_low=0, push fetch_data[15:0] then [31:16] (level +2).
REQ-021 SHALL, on a fetch handshake with drop_low=1, push only fetch_data[31:16] (level +1) and clear drop_low.
REQ-022 SHALL assert out_valid when level >= 1 and head is compressed, or when level >= 2; out_valid is low during redirect.
REQ-023 SHALL drive out_instr = {16'b0, h0} when compressed, else {h1, h0}, where h0 is the head halfword and h1 the next.
REQ-024 SHALL, on out handshake, pop 1 halfword and add 2 to pc_q if compressed, else pop 2 and add 4; pc_q wraps modulo 2^32.
REQ-025 SHALL support a fetch push and an out pop in the same cycle: level_next = level + pushed - popped.
REQ-026 SHALL have latency one cycle: a word accepted at edge N is visible on out_* after edge N.
REQ-027 SHALL keep a 32-bit instruction whose halves span two fetch words invisible until both halves are buffered (out_valid=0 with level=1).
REQ-028 SHALL, on redirect, at the clock edge: level to 0, pc_q to {redirect_pc[31:1], 1'b0}, and drop_low to redirect_pc[1].
REQ-029 SHALL give redirect priority: no fetch or out handshake occurs in a redirect cycle.
REQ-030 SHALL, with ENABLE_C=0, treat every head as 32-bit and still emit it with out_illegal=1 when head[1:0] != 2'b11.
REQ-031 SHALL hold out_* stable while out_valid=1 and out_ready=0, absent redirect.
REQ-032 SHALL never overflow or underflow; the FIFO wraps its read and write pointers modulo DEPTH.

Reset
REQ-033 SHALL, while reset is high, asynchronously force level=0, pc_q=RESET_PC, drop_low=0, and pointers=0.
REQ-034 SHALL keep out_valid=0 and fetch_ready=0 while reset is high.
REQ-035 SHALL discard any partially buffered instruction when reset is asserted mid-operation.

Verification
REQ-036 SHALL cover mixed stream: words 32'h0001_4501, 32'h0000_0513 -> outputs 16'h4501@0, 16'h0001@2, 32'h0000_0513@4.
REQ-037 SHALL cover straddle: words 32'h0513_4501, 32'h0000_0000 -> 16'h4501@0; 32'h0000_0513@2 only after the second word is accepted.
REQ-038 SHALL cover redirect to 32'h100A: next word 32'h8082_xxxx -> 16'h8082@100A with level peaking at 1.
REQ-039 SHALL cover backpressure: out_ready=0 with DEPTH=8 and 4 words sent -> fetch_ready=0 at level 8, out_* stable, no data loss.
REQ-040 SHALL cover ENABLE_C=0: word 32'h4501_4501 -> one 32-bit instruction with out_illegal=1@RESET_PC.
REQ-041 SHALL cover reset mid-straddle (level=1): reset -> level=0, out_pc=RESET_PC, out_valid=0.

Source files
------------

// File: rtl/instr_aligner.sv
// instr_aligner: realigns a 32-bit fetch word stream into 16/32-bit RISC-V instructions
module instr_aligner #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ENABLE_C = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         fetch_valid,
   output logic                         fetch_ready,
   input  logic [31:0]                  fetch_data,
   input  logic                         redirect,
   input  logic [31:0]                  redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [31:0]                  out_instr,
   output logic [31:0]                  out_pc,
   output logic                         out_compressed,
   output logic                         out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_p1, wr_p1;
   logic [LW-1:0] level_q, level_d, push_n, pop_n;
   logic [31:0]   pc_q, pc_d;
   logic          drop_q, drop_d;
   logic [15:0]   h0, h1;
   logic          is_c, fetch_fire, out_fire;

   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      return PW'(s >= DEPTH ? s - DEPTH : s);
   endfunction

   assign rd_p1          = adv(rd_q, 1);
   assign wr_p1          = adv(wr_q, 1);
   assign h0             = mem_q[rd_q];
   assign h1             = mem_q[rd_p1];
   assign is_c           = (ENABLE_C != 0) && (h0[1:0] != 2'b11);
   assign fetch_ready    = !reset && !redirect && (level_q <= LW'(DEPTH - 2));
   assign out_valid      = !reset && !redirect && ((level_q >= LW'(2)) || (level_q != '0 && is_c));
   assign fetch_fire     = fetch_valid && fetch_ready;
   assign out_fire       = out_valid && out_ready;
   assign out_instr      = is_c ? {16'h0000, h0} : {h1, h0};
   assign out_pc         = pc_q;
   assign out_compressed = is_c;
   assign out_illegal    = (ENABLE_C == 0) && (h0[1:0] != 2'b11);
   assign level          = level_q;

   // next state: redirect flushes everything, otherwise push and pop combine freely
   always_comb begin
      push_n  = fetch_fire ? (drop_q ? LW'(1) : LW'(2)) : '0;
      pop_n   = out_fire ? (is_c ? LW'(1) : LW'(2)) : '0;
      level_d = redirect ? '0 : level_q + push_n - pop_n;
      wr_d    = redirect ? '0 : adv(wr_q, int'(push_n));
      rd_d    = redirect ? '0 : adv(rd_q, int'(pop_n));
      pc_d    = redirect ? (redirect_pc & 32'hFFFF_FFFE)
                         : pc_q + (out_fire ? (is_c ? 32'd2 : 32'd4) : 32'd0);
      drop_d  = redirect ? redirect_pc[1] : (drop_q && !fetch_fire);
   end

   // control state with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   // halfword storage; an odd redirect target skips the low half of the first word
   always_ff @(posedge clk) begin
      if (fetch_fire) begin
         if (drop_q) begin
            mem_q[wr_q] <= fetch_data[31:16];
         end else begin
            mem_q[wr_q]  <= fetch_data[15:0];
            mem_q[wr_p1] <= fetch_data[31:16];
         end
      end
   end
endmodule
